bcd_display_driver: RTL and testbench

Sequential display back-end for the 16-bit FPGA CPU. It accepts a 16-bit result word through a valid/ready handshake and converts it to decimal with an iterative shift-add-3 (double-dabble) engine. It then drives the four active-low seven-segment digits HEX3..HEX0 from registers and holds each value until the next conversion completes. It replaces the combinational divide/modulo digit logic on the CPU's write-data path.

---
 rtl/seg7_pkg.sv | 24 ++
 rtl/seg7_encode.sv | 23 ++
 rtl/bcd_display_driver.sv | 127 ++++++++++++
 tb/tb_bcd_display_driver.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared definitions for the BCD seven-segment display back-end.
// Contents: FSM state type, active-low segment table for digits 0-9,
// blank code and digit/iteration counts used by the converter.
package seg7_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CONVERT = 2'd1,
      LOAD    = 2'd2
   } state_t;

   localparam int NUM_DIGITS = 4;
   localparam int BCD_DIGITS = 5;
   localparam int ITERATIONS = 16;

   localparam logic [6:0] SEG_BLANK = 7'h7F;

   // Active-low segments, bit0=a .. bit6=g, indexed by decimal digit
   localparam logic [6:0] SEG_TABLE [10] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
      7'h12, 7'h02, 7'h78, 7'h00, 7'h10
   };

endpackage

// File: rtl/seg7_encode.sv
// Combinational seven-segment encoder for one decimal digit.
// Ports:
//   i_digit  BCD digit 0-9 (other codes display as blank)
//   i_blank  force the digit off
//   o_seg    active-low segments, bit0=a .. bit6=g
module seg7_encode
   import seg7_pkg::*;
(
   input  logic [3:0] i_digit,
   input  logic       i_blank,
   output logic [6:0] o_seg
);

   always_comb begin
      o_seg = SEG_BLANK;
      if (!i_blank) begin
         for (int i = 0; i < 10; i++) begin
            if (i_digit == 4'(i)) o_seg = SEG_TABLE[i];
         end
      end
   end

endmodule

// File: rtl/bcd_display_driver.sv
// Sequential display back-end: accepts a 16-bit word over valid/ready,
// converts it to BCD with a 16-step shift-add-3 engine and registers the
// four active-low seven-segment digits, holding them until the next load.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   in_valid/in_data      producer word, consumed when in_ready is high
//   in_ready              high only while idle
//   busy                  conversion (and load) in progress
//   hex3..hex0            active-low segments, hex3 = thousands digit
//   ovf                   last displayed value exceeded 9999
//   shown                 a value has been displayed since reset
module bcd_display_driver
   import seg7_pkg::*;
#(
   parameter int LEADING_BLANK = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   input  logic [15:0] in_data,
   output logic        in_ready,
   output logic        busy,
   output logic [6:0]  hex3,
   output logic [6:0]  hex2,
   output logic [6:0]  hex1,
   output logic [6:0]  hex0,
   output logic        ovf,
   output logic        shown
);

   state_t      r_state;
   logic [3:0]  r_iter;
   logic [35:0] r_dd;      // {bcd[19:0], shift[15:0]}
   logic [6:0]  r_hex [NUM_DIGITS];
   logic        r_ovf;
   logic        r_shown;
   logic        r_ready;
   logic        r_busy;

   logic [19:0] w_bcd_adj;
   logic [3:0]  w_digit [NUM_DIGITS];
   logic        w_blank [NUM_DIGITS];
   logic [6:0]  w_seg   [NUM_DIGITS];
   logic        w_ovf;

   // Add-3 correction applied to every BCD nibble before the shift
   always_comb begin
      w_bcd_adj = r_dd[35:16];
      for (int i = 0; i < BCD_DIGITS; i++) begin
         if (r_dd[16 + 4*i +: 4] >= 4'd5)
            w_bcd_adj[4*i +: 4] = r_dd[16 + 4*i +: 4] + 4'd3;
      end
   end

   assign w_ovf = (r_dd[35:32] != 4'd0);

   // Leading-zero blanking chains down from the thousands digit and is
   // suppressed entirely on overflow so the mod-10000 value reads in full.
   always_comb begin
      for (int k = 0; k < NUM_DIGITS; k++) w_digit[k] = r_dd[16 + 4*k +: 4];
      w_blank[3] = (LEADING_BLANK != 0) && !w_ovf && (w_digit[3] == 4'd0);
      w_blank[2] = w_blank[3] && (w_digit[2] == 4'd0);
      w_blank[1] = w_blank[2] && (w_digit[1] == 4'd0);
      w_blank[0] = 1'b0;
   end

   for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_enc
      seg7_encode u_enc (
         .i_digit (w_digit[g]),
         .i_blank (w_blank[g]),
         .o_seg   (w_seg[g])
      );
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= IDLE;
         r_iter  <= 4'd0;
         r_dd    <= 36'd0;
         for (int k = 0; k < NUM_DIGITS; k++) r_hex[k] <= SEG_BLANK;
         r_ovf   <= 1'b0;
         r_shown <= 1'b0;
         r_ready <= 1'b1;
         r_busy  <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (in_valid) begin
                  r_dd    <= {20'd0, in_data};
                  r_iter  <= 4'd0;
                  r_state <= CONVERT;
                  r_ready <= 1'b0;
                  r_busy  <= 1'b1;
               end
            end
            CONVERT: begin
               r_dd   <= {w_bcd_adj, r_dd[15:0]} << 1;
               r_iter <= r_iter + 4'd1;
               if (r_iter == 4'(ITERATIONS - 1)) r_state <= LOAD;
            end
            LOAD: begin
               for (int k = 0; k < NUM_DIGITS; k++) r_hex[k] <= w_seg[k];
               r_ovf   <= w_ovf;
               r_shown <= 1'b1;
               r_state <= IDLE;
               r_ready <= 1'b1;
               r_busy  <= 1'b0;
            end
            default: begin
               r_state <= IDLE;
               r_ready <= 1'b1;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready = r_ready;
   assign busy     = r_busy;
   assign hex3     = r_hex[3];
   assign hex2     = r_hex[2];
   assign hex1     = r_hex[1];
   assign hex0     = r_hex[0];
   assign ovf      = r_ovf;
   assign shown    = r_shown;

endmodule

// File: tb/tb_bcd_display_driver.sv
// Directed bench for bcd_display_driver: a default instance (leading
// blanking on) and a second instance with blanking off share the stimulus.
module tb_bcd_display_driver;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic [15:0] in_data;

   logic       in_ready, busy, ovf, shown;
   logic [6:0] hex3, hex2, hex1, hex0;
   logic       nb_in_ready, nb_busy, nb_ovf, nb_shown;
   logic [6:0] nb_hex3, nb_hex2, nb_hex1, nb_hex0;

   logic [27:0] w_disp, w_nb_disp;
   assign w_disp    = {hex3, hex2, hex1, hex0};
   assign w_nb_disp = {nb_hex3, nb_hex2, nb_hex1, nb_hex0};

   localparam logic [27:0] D_BLANK = {7'h7F, 7'h7F, 7'h7F, 7'h7F};
   localparam logic [27:0] D_0     = {7'h7F, 7'h7F, 7'h7F, 7'h40};
   localparam logic [27:0] D_1234  = {7'h79, 7'h24, 7'h30, 7'h19};
   localparam logic [27:0] D_9999  = {7'h10, 7'h10, 7'h10, 7'h10};
   localparam logic [27:0] D_5535  = {7'h12, 7'h12, 7'h30, 7'h12};
   localparam logic [27:0] D_7     = {7'h7F, 7'h7F, 7'h7F, 7'h78};
   localparam logic [27:0] D_7_NB  = {7'h40, 7'h40, 7'h40, 7'h78};
   localparam logic [27:0] D_42    = {7'h7F, 7'h7F, 7'h19, 7'h24};

   bcd_display_driver u_dut (
      .clk      (clk),
      .reset    (reset),
      .in_valid (in_valid),
      .in_data  (in_data),
      .in_ready (in_ready),
      .busy     (busy),
      .hex3     (hex3),
      .hex2     (hex2),
      .hex1     (hex1),
      .hex0     (hex0),
      .ovf      (ovf),
      .shown    (shown)
   );

   bcd_display_driver #(.LEADING_BLANK(0)) u_nb (
      .clk      (clk),
      .reset    (reset),
      .in_valid (in_valid),
      .in_data  (in_data),
      .in_ready (nb_in_ready),
      .busy     (nb_busy),
      .hex3     (nb_hex3),
      .hex2     (nb_hex2),
      .hex1     (nb_hex1),
      .hex0     (nb_hex0),
      .ovf      (nb_ovf),
      .shown    (nb_shown)
   );

   always #10 clk = ~clk;

   int n_total = 0;
   int n_bad   = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Counts busy cycles after an accept and checks the old display holds.
   // With poke set, a stray in_valid pulse is offered mid-conversion.
   task automatic wait_idle(input string tag, input logic [27:0] prev, input bit poke);
      int cnt = 0;
      bit stable = 1'b1;
      while (busy && cnt < 40) begin
         if (w_disp !== prev) stable = 1'b0;
         if (poke && cnt == 5) begin
            in_valid = 1'b1;
            in_data  = 16'd8888;
         end else if (poke && cnt == 6) begin
            in_valid = 1'b0;
         end
         cnt++;
         tick();
      end
      chk({tag, "_busy_cycles"}, cnt, 17);
      chk({tag, "_stable"}, {31'd0, stable}, 32'd1);
      chk({tag, "_ready"}, {31'd0, in_ready}, 32'd1);
   endtask

   task automatic convert(input string tag, input logic [15:0] v, input logic [27:0] prev);
      in_valid = 1'b1;
      in_data  = v;
      tick();
      in_valid = 1'b0;
      in_data  = ~v;
      chk({tag, "_accepted"}, {31'd0, busy}, 32'd1);
      wait_idle(tag, prev, 1'b1);
   endtask

   initial begin
      reset    = 1'b1;
      in_valid = 1'b1;
      in_data  = 16'd1234;
      tick();
      tick();
      in_valid = 1'b0;
      tick();
      chk("rst_hex",   {4'd0, w_disp}, {4'd0, D_BLANK});
      chk("rst_ready", {31'd0, in_ready}, 32'd1);
      chk("rst_busy",  {31'd0, busy}, 32'd0);
      chk("rst_ovf",   {31'd0, ovf}, 32'd0);
      chk("rst_shown", {31'd0, shown}, 32'd0);
      chk("rst_nb_hex", {4'd0, w_nb_disp}, {4'd0, D_BLANK});
      reset = 1'b0;
      tick();
      chk("idle_busy", {31'd0, busy}, 32'd0);

      convert("v0", 16'd0, D_BLANK);
      chk("v0_hex",   {4'd0, w_disp}, {4'd0, D_0});
      chk("v0_ovf",   {31'd0, ovf}, 32'd0);
      chk("v0_shown", {31'd0, shown}, 32'd1);

      convert("v1234", 16'd1234, D_0);
      chk("v1234_hex", {4'd0, w_disp}, {4'd0, D_1234});

      // Back-to-back words with in_valid held high
      in_valid = 1'b1;
      in_data  = 16'd9999;
      tick();
      in_data  = 16'hFFFF;
      wait_idle("v9999", D_1234, 1'b0);
      chk("v9999_hex", {4'd0, w_disp}, {4'd0, D_9999});
      chk("v9999_ovf", {31'd0, ovf}, 32'd0);
      tick();
      in_valid = 1'b0;
      chk("v65535_accepted", {31'd0, busy}, 32'd1);
      wait_idle("v65535", D_9999, 1'b0);
      chk("v65535_hex", {4'd0, w_disp}, {4'd0, D_5535});
      chk("v65535_ovf", {31'd0, ovf}, 32'd1);

      convert("v7", 16'd7, D_5535);
      chk("v7_hex",    {4'd0, w_disp}, {4'd0, D_7});
      chk("v7_nb_hex", {4'd0, w_nb_disp}, {4'd0, D_7_NB});
      chk("v7_ovf",    {31'd0, ovf}, 32'd0);

      convert("v42", 16'd42, D_7);
      chk("v42_hex", {4'd0, w_disp}, {4'd0, D_42});

      // Reset in the middle of converting 500
      in_valid = 1'b1;
      in_data  = 16'd500;
      tick();
      in_valid = 1'b0;
      repeat (8) tick();
      chk("mid_busy", {31'd0, busy}, 32'd1);
      chk("mid_hex",  {4'd0, w_disp}, {4'd0, D_42});
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("mid_rst_hex",   {4'd0, w_disp}, {4'd0, D_BLANK});
      chk("mid_rst_shown", {31'd0, shown}, 32'd0);
      chk("mid_rst_ready", {31'd0, in_ready}, 32'd1);
      chk("mid_rst_busy",  {31'd0, busy}, 32'd0);
      repeat (25) tick();
      chk("after_rst_hex",   {4'd0, w_disp}, {4'd0, D_BLANK});
      chk("after_rst_shown", {31'd0, shown}, 32'd0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
